// File: rtl/render_ctrl_pkg.sv
// rtl/render_ctrl_pkg.sv - register map, bit positions and run-state type for render_ctrl_regs
package render_ctrl_pkg;

  localparam int ADDR_FB_BASE   = 'h000;
  localparam int ADDR_VB_BASE   = 'h004;
  localparam int ADDR_CTRL      = 'h008;
  localparam int ADDR_STATUS    = 'h00C;
  localparam int ADDR_FRAME_CNT = 'h010;
  localparam int ADDR_ID        = 'h500;

  // Array registers live in 256-byte pages selected by address[ADDR_W-1:8]
  localparam int PAGE_MV    = 1;
  localparam int PAGE_MVP   = 2;
  localparam int PAGE_LIGHT = 3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_ERR_BIT  = 2;

  localparam logic [31:0] ID_VALUE = 32'hDEADBEEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shadow_reg_bank.sv
// rtl/shadow_reg_bank.sv - staging register array with indexed access and atomic commit to active copy
module shadow_reg_bank #(
  parameter int          N         = 1,
  parameter int          W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [7:0]          i_wr_idx,
  input  logic [W-1:0]        i_wr_data,
  input  logic [7:0]          i_rd_idx,
  output logic [W-1:0]        o_rd_data,
  input  logic                i_commit,
  output logic [N-1:0][W-1:0] o_active
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][W-1:0] r_stage;
  logic [N-1:0][W-1:0] r_active;
  logic                w_wr_hit;
  logic                w_rd_hit;

  assign w_wr_hit = i_wr_en && (int'(i_wr_idx) < N);
  assign w_rd_hit = (int'(i_rd_idx) < N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage  <= {N{RESET_VAL}};
      r_active <= {N{RESET_VAL}};
    end else begin
      if (w_wr_hit) begin
        r_stage[i_wr_idx[IDX_W-1:0]] <= i_wr_data;
      end
      if (i_commit) begin
        r_active <= r_stage;
      end
    end
  end

  assign o_rd_data = w_rd_hit ? r_stage[i_rd_idx[IDX_W-1:0]] : '0;
  assign o_active  = r_active;

endmodule

// File: rtl/render_ctrl_regs.sv
// rtl/render_ctrl_regs.sv - render pipeline CSR file: shadowed matrices/bases, run FSM, sticky status, frame counter
module render_ctrl_regs
  import render_ctrl_pkg::*;
#(
  parameter int                NUM_MAT   = 16,
  parameter int                NUM_LIGHT = 3,
  parameter int                ADDR_W    = 16,
  parameter int                BASE_W    = 26,
  parameter logic [BASE_W-1:0] VB_RESET  = 26'h300000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        write,
  input  logic                        read,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic                        readdatavalid,
  output logic [NUM_MAT-1:0][31:0]    MV,
  output logic [NUM_MAT-1:0][31:0]    MVP,
  output logic [NUM_LIGHT-1:0][31:0]  lighting,
  output logic [BASE_W-1:0]           frame_buffer_base,
  output logic [BASE_W-1:0]           vertex_buffer_base,
  output logic                        start_render,
  input  logic                        done_in,
  output logic                        irq
);

  localparam int PAGE_W = ADDR_W - 8;

  state_t             r_state;
  state_t             w_state_d;
  logic               w_launch;
  logic               w_reject;
  logic               w_finish;

  logic               r_start;
  logic               r_done;
  logic               r_err;
  logic               r_irq_en;
  logic [31:0]        r_frame_cnt;
  logic [31:0]        r_rdata;
  logic               r_rvalid;
  logic [31:0]        w_rdata;

  logic [PAGE_W-1:0]  w_page;
  logic [7:0]         w_idx;
  logic               w_sel_fb, w_sel_vb, w_sel_ctrl, w_sel_status;
  logic               w_sel_frame, w_sel_id;
  logic               w_sel_mv, w_sel_mvp, w_sel_light;
  logic               w_start_req;
  logic               w_busy;

  logic [31:0]        w_mv_rd, w_mvp_rd, w_light_rd;
  logic [BASE_W-1:0]  w_fb_rd, w_vb_rd;

  assign w_page       = address[ADDR_W-1:8];
  assign w_idx        = {2'b00, address[7:2]};
  assign w_sel_fb     = (address == ADDR_W'(ADDR_FB_BASE));
  assign w_sel_vb     = (address == ADDR_W'(ADDR_VB_BASE));
  assign w_sel_ctrl   = (address == ADDR_W'(ADDR_CTRL));
  assign w_sel_status = (address == ADDR_W'(ADDR_STATUS));
  assign w_sel_frame  = (address == ADDR_W'(ADDR_FRAME_CNT));
  assign w_sel_id     = (address == ADDR_W'(ADDR_ID));
  assign w_sel_mv     = (w_page == PAGE_W'(PAGE_MV));
  assign w_sel_mvp    = (w_page == PAGE_W'(PAGE_MVP));
  assign w_sel_light  = (w_page == PAGE_W'(PAGE_LIGHT));

  assign w_start_req  = write && w_sel_ctrl && writedata[CTRL_START_BIT];
  assign w_busy       = (r_state == RUN);

  shadow_reg_bank #(.N(NUM_MAT), .W(32)) u_mv (
    .clk(clk), .rst(reset),
    .i_wr_en(write && w_sel_mv), .i_wr_idx(w_idx), .i_wr_data(writedata),
    .i_rd_idx(w_idx), .o_rd_data(w_mv_rd),
    .i_commit(w_launch), .o_active(MV)
  );

  shadow_reg_bank #(.N(NUM_MAT), .W(32)) u_mvp (
    .clk(clk), .rst(reset),
    .i_wr_en(write && w_sel_mvp), .i_wr_idx(w_idx), .i_wr_data(writedata),
    .i_rd_idx(w_idx), .o_rd_data(w_mvp_rd),
    .i_commit(w_launch), .o_active(MVP)
  );

  shadow_reg_bank #(.N(NUM_LIGHT), .W(32)) u_light (
    .clk(clk), .rst(reset),
    .i_wr_en(write && w_sel_light), .i_wr_idx(w_idx), .i_wr_data(writedata),
    .i_rd_idx(w_idx), .o_rd_data(w_light_rd),
    .i_commit(w_launch), .o_active(lighting)
  );

  shadow_reg_bank #(.N(1), .W(BASE_W), .RESET_VAL('0)) u_fb (
    .clk(clk), .rst(reset),
    .i_wr_en(write && w_sel_fb), .i_wr_idx(8'd0), .i_wr_data(writedata[BASE_W-1:0]),
    .i_rd_idx(8'd0), .o_rd_data(w_fb_rd),
    .i_commit(w_launch), .o_active(frame_buffer_base)
  );

  shadow_reg_bank #(.N(1), .W(BASE_W), .RESET_VAL(VB_RESET)) u_vb (
    .clk(clk), .rst(reset),
    .i_wr_en(write && w_sel_vb), .i_wr_idx(8'd0), .i_wr_data(writedata[BASE_W-1:0]),
    .i_rd_idx(8'd0), .o_rd_data(w_vb_rd),
    .i_commit(w_launch), .o_active(vertex_buffer_base)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_launch  = 1'b0;
    w_reject  = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_req) begin
          w_launch  = 1'b1;
          w_state_d = RUN;
        end
      end
      RUN: begin
        w_reject = w_start_req;
        if (done_in) begin
          w_finish  = 1'b1;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Completion set takes priority over a same-cycle write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_irq_en    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_start <= w_launch;
      if (write && w_sel_ctrl) begin
        r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
      end
      if (w_launch) begin
        r_done <= 1'b0;
      end else if (w_finish) begin
        r_done <= 1'b1;
      end else if (write && w_sel_status && writedata[STATUS_DONE_BIT]) begin
        r_done <= 1'b0;
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end else if (write && w_sel_status && writedata[STATUS_ERR_BIT]) begin
        r_err <= 1'b0;
      end
      if (w_finish) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_sel_fb) begin
      w_rdata = 32'(w_fb_rd);
    end else if (w_sel_vb) begin
      w_rdata = 32'(w_vb_rd);
    end else if (w_sel_ctrl) begin
      w_rdata = {29'd0, r_irq_en, w_busy, r_done};
    end else if (w_sel_status) begin
      w_rdata = {29'd0, r_err, w_busy, r_done};
    end else if (w_sel_frame) begin
      w_rdata = r_frame_cnt;
    end else if (w_sel_id) begin
      w_rdata = ID_VALUE;
    end else if (w_sel_mv) begin
      w_rdata = w_mv_rd;
    end else if (w_sel_mvp) begin
      w_rdata = w_mvp_rd;
    end else if (w_sel_light) begin
      w_rdata = w_light_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= read;
      if (read) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign readdata      = r_rdata;
  assign readdatavalid = r_rvalid;
  assign start_render  = r_start;
  assign irq           = r_done && r_irq_en;

endmodule

// File: tb/tb_render_ctrl_regs.sv
// tb/tb_render_ctrl_regs.sv - directed self-checking bench for render_ctrl_regs
module tb_render_ctrl_regs;

  logic                clk;
  logic                reset;
  logic [15:0]         address;
  logic                write;
  logic                read;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic                readdatavalid;
  logic [15:0][31:0]   MV;
  logic [15:0][31:0]   MVP;
  logic [2:0][31:0]    lighting;
  logic [25:0]         frame_buffer_base;
  logic [25:0]         vertex_buffer_base;
  logic                start_render;
  logic                done_in;
  logic                irq;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int snap;

  render_ctrl_regs dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .MV(MV), .MVP(MVP), .lighting(lighting),
    .frame_buffer_base(frame_buffer_base), .vertex_buffer_base(vertex_buffer_base),
    .start_render(start_render), .done_in(done_in), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (start_render) n_starts++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    check_eq({tag, "_valid"}, 32'(readdatavalid), 32'd1);
    check_eq(tag, readdata, exp);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done_in = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    address   = '0;
    write     = 1'b0;
    read      = 1'b0;
    writedata = '0;
    done_in   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", readdata, 32'd0);
    check_eq("rst_rvalid", 32'(readdatavalid), 32'd0);
    check_eq("rst_start", 32'(start_render), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_vb_active", 32'(vertex_buffer_base), 32'h00300000);
    check_eq("rst_mv3", MV[3], 32'd0);
    reset = 1'b0;

    read_check("rd_vb", 16'h004, 32'h00300000);
    @(negedge clk);
    check_eq("rvalid_drop", 32'(readdatavalid), 32'd0);
    check_eq("rdata_hold", readdata, 32'h00300000);
    read_check("rd_id", 16'h500, 32'hDEADBEEF);
    read_check("rd_ctrl", 16'h008, 32'd0);

    // staging vs active
    bus_write(16'h10C, 32'h3F800000);
    bus_write(16'h000, 32'hFFFFFFFF);
    read_check("rd_mv3_stage", 16'h10C, 32'h3F800000);
    read_check("rd_fb_stage", 16'h000, 32'h03FFFFFF);
    check_eq("mv3_pre_start", MV[3], 32'd0);
    check_eq("fb_pre_start", 32'(frame_buffer_base), 32'd0);
    bus_write(16'h008, 32'd1);
    check_eq("start_pulse", 32'(start_render), 32'd1);
    check_eq("mv3_at_start", MV[3], 32'h3F800000);
    check_eq("fb_at_start", 32'(frame_buffer_base), 32'h03FFFFFF);
    @(negedge clk);
    check_eq("start_drop", 32'(start_render), 32'd0);
    bus_write(16'h10C, 32'h40000000);
    check_eq("mv3_run_stage", MV[3], 32'h3F800000);
    read_check("rd_mv3_run", 16'h10C, 32'h40000000);
    read_check("st_busy", 16'h00C, 32'd2);
    pulse_done();
    check_eq("irq_masked", 32'(irq), 32'd0);
    read_check("st_doneA", 16'h00C, 32'd1);
    read_check("frameA", 16'h010, 32'd1);

    // irq path
    bus_write(16'h008, 32'd3);
    read_check("ctrl_run_irq", 16'h008, 32'd6);
    repeat (10) @(negedge clk);
    pulse_done();
    check_eq("irq_set", 32'(irq), 32'd1);
    read_check("st_doneB", 16'h00C, 32'd1);
    read_check("frameB", 16'h010, 32'd2);
    bus_write(16'h00C, 32'd1);
    check_eq("irq_clr", 32'(irq), 32'd0);
    read_check("st_clrB", 16'h00C, 32'd0);

    // overlapping start
    snap = n_starts;
    bus_write(16'h008, 32'd1);
    bus_write(16'h008, 32'd1);
    repeat (2) @(negedge clk);
    check_eq("single_start", 32'(n_starts - snap), 32'd1);
    read_check("st_err", 16'h00C, 32'd6);
    bus_write(16'h00C, 32'd4);
    read_check("st_err_clr", 16'h00C, 32'd2);
    pulse_done();
    read_check("st_doneC", 16'h00C, 32'd1);
    read_check("frameC", 16'h010, 32'd3);

    // done_in while idle
    bus_write(16'h00C, 32'd1);
    pulse_done();
    read_check("idle_done_st", 16'h00C, 32'd0);
    read_check("idle_done_frame", 16'h010, 32'd3);

    // W1C collides with done_in: set wins
    bus_write(16'h008, 32'd1);
    @(negedge clk);
    address = 16'h00C; writedata = 32'd1; write = 1'b1; done_in = 1'b1;
    @(negedge clk);
    write = 1'b0; done_in = 1'b0;
    read_check("w1c_race", 16'h00C, 32'd1);
    read_check("frameD", 16'h010, 32'd4);

    // start request in the done_in cycle
    snap = n_starts;
    bus_write(16'h008, 32'd1);
    @(negedge clk);
    address = 16'h008; writedata = 32'd1; write = 1'b1; done_in = 1'b1;
    @(negedge clk);
    write = 1'b0; done_in = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("race_starts", 32'(n_starts - snap), 32'd1);
    read_check("start_done_race", 16'h00C, 32'd5);
    read_check("frameE", 16'h010, 32'd5);
    bus_write(16'h00C, 32'd5);

    // RO / unmapped / out-of-range
    bus_write(16'h30C, 32'h000000AA);
    read_check("light3_oor", 16'h30C, 32'd0);
    bus_write(16'h500, 32'd0);
    read_check("id_ro", 16'h500, 32'hDEADBEEF);
    read_check("unmapped", 16'h600, 32'd0);
    bus_write(16'h010, 32'd7);
    read_check("frame_ro", 16'h010, 32'd5);
    bus_write(16'h23C, 32'h12345678);
    read_check("mvp15", 16'h23C, 32'h12345678);

    // reset mid-RUN
    bus_write(16'h300, 32'h00001234);
    bus_write(16'h004, 32'h00000055);
    bus_write(16'h008, 32'd1);
    check_eq("light0_active", lighting[0], 32'h00001234);
    check_eq("vb_active", 32'(vertex_buffer_base), 32'h00000055);
    check_eq("mvp15_active", MVP[15], 32'h12345678);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_start", 32'(start_render), 32'd0);
    check_eq("mid_rst_rdata", readdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    snap = n_starts;
    pulse_done();
    check_eq("post_rst_irq", 32'(irq), 32'd0);
    read_check("post_rst_st", 16'h00C, 32'd0);
    read_check("post_rst_frame", 16'h010, 32'd0);
    check_eq("post_rst_light0", lighting[0], 32'd0);
    check_eq("post_rst_vb", 32'(vertex_buffer_base), 32'h00300000);
    check_eq("post_rst_mv3", MV[3], 32'd0);
    check_eq("post_rst_fb", 32'(frame_buffer_base), 32'd0);
    check_eq("post_rst_nostart", 32'(n_starts - snap), 32'd0);
    read_check("post_rst_light_stage", 16'h300, 32'd0);
    read_check("post_rst_vb_stage", 16'h004, 32'h00300000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
